aes_stream_packer: RTL and testbench

- Data-path adapter between the HWPE streamer and the AES round core, driven by the engine control that the AES control FSM issues (clear/start/enable).
- Packs the 32-bit plaintext source stream into 128-bit blocks for the core.
- Unpacks the core's 128-bit ciphertext blocks into the 32-bit sink stream.
- Counts blocks and reports completion back to the control FSM.

---
 rtl/aes_stream_packer_if.sv | 20 ++
 rtl/aes_stream_packer.sv | 163 ++++++++++++++++
 tb/tb_aes_stream_packer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_packer_if.sv
// -----------------------------------------------------------------------------
// aes_stream_packer_if
// Valid/ready stream bundle used on the four data ports of aes_stream_packer.
//   valid : producer has a word/block on data
//   ready : consumer can take it this cycle
//   data  : payload, W bits
// A transfer happens on a rising edge where valid && ready. The producer keeps
// valid high and data stable until that transfer.
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface aes_stream_packer_if #(
    parameter int W = 32
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/aes_stream_packer.sv
// -----------------------------------------------------------------------------
// aes_stream_packer
// Adapter between the HWPE streamer and the AES round core. Packs the 32-bit
// plaintext stream into 128-bit blocks, unpacks 128-bit ciphertext blocks into
// the 32-bit sink stream, counts blocks and reports job completion.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   clear          synchronous clear, same effect as reset
//   start_i        job start (IDLE only), latches nb_blocks_i
//   enable_i       0 blocks new acceptances (pt/ctb ready forced low)
//   nb_blocks_i    number of blocks in the job
//   pt   (slave)   plaintext words in
//   blk  (master)  packed plaintext blocks out to the core
//   ctb  (slave)   ciphertext blocks in from the core
//   ct   (master)  ciphertext words out to the sink
//   busy_o         job in progress (RUN or DONE)
//   done_o         one-cycle completion pulse
//   in_cnt_o       blocks handed to the core
//   out_cnt_o      blocks fully emitted to the sink
//
// State | meaning
// ------+----------------------------------------------------
// IDLE  | waiting for start_i
// RUN   | packing/unpacking until the last ct word is taken
// DONE  | done_o pulse, returns to IDLE next cycle
// -----------------------------------------------------------------------------
module aes_stream_packer #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128,
    parameter int CNT_W   = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       start_i,
    input  logic                       enable_i,
    input  logic [CNT_W-1:0]           nb_blocks_i,
    aes_stream_packer_if.slave         pt,
    aes_stream_packer_if.master        blk,
    aes_stream_packer_if.slave         ctb,
    aes_stream_packer_if.master        ct,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [CNT_W-1:0]           in_cnt_o,
    output logic [CNT_W-1:0]           out_cnt_o
);
    localparam int WPB   = BLOCK_W / WORD_W;
    localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0]   nb_q, in_cnt_q, out_cnt_q;
    logic [IDX_W-1:0]   pk_idx_q, ub_idx_q;
    logic [BLOCK_W-1:0] pk_data_q, ub_data_q;
    logic               blk_valid_q, ub_full_q;

    logic run, job_start, pt_fire, blk_fire, ctb_fire, ct_fire, last_word, job_end;

    assign run       = (state_q == RUN);
    assign job_start = (state_q == IDLE) && start_i;

    assign pt.ready  = run && enable_i && !blk_valid_q && (in_cnt_q < nb_q);
    assign ctb.ready = run && enable_i && !ub_full_q;
    assign blk.valid = blk_valid_q;
    assign blk.data  = pk_data_q;
    assign ct.valid  = ub_full_q;
    // The unpack buffer shifts left on every word, so the current word is
    // always in the top slice.
    assign ct.data   = ub_data_q[BLOCK_W-1 -: WORD_W];

    // Output-side transfers ignore enable_i so a raised valid is never stranded.
    assign pt_fire   = pt.valid && pt.ready;
    assign blk_fire  = blk_valid_q && blk.ready;
    assign ctb_fire  = ctb.valid && ctb.ready;
    assign ct_fire   = ub_full_q && ct.ready;
    assign last_word = ct_fire && (ub_idx_q == LAST_IDX);
    assign job_end   = run && last_word && ((out_cnt_q + CNT_W'(1)) == nb_q);

    assign busy_o    = (state_q == RUN) || (state_q == DONE);
    assign done_o    = (state_q == DONE);
    assign in_cnt_o  = in_cnt_q;
    assign out_cnt_o = out_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = (nb_blocks_i == '0) ? DONE : RUN;
            RUN:     if (job_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nb_q        <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            pk_idx_q    <= '0;
            ub_idx_q    <= '0;
            pk_data_q   <= '0;
            ub_data_q   <= '0;
            blk_valid_q <= 1'b0;
            ub_full_q   <= 1'b0;
        end else if (clear) begin
            nb_q        <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            pk_idx_q    <= '0;
            ub_idx_q    <= '0;
            pk_data_q   <= '0;
            ub_data_q   <= '0;
            blk_valid_q <= 1'b0;
            ub_full_q   <= 1'b0;
        end else if (job_start) begin
            nb_q        <= nb_blocks_i;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            pk_idx_q    <= '0;
            ub_idx_q    <= '0;
            blk_valid_q <= 1'b0;
            ub_full_q   <= 1'b0;
        end else begin
            // Pack: shift words in from the LSB end so the first word ends in the MSBs.
            if (pt_fire) begin
                pk_data_q <= {pk_data_q[BLOCK_W-WORD_W-1:0], pt.data};
                pk_idx_q  <= (pk_idx_q == LAST_IDX) ? '0 : pk_idx_q + IDX_W'(1);
                if (pk_idx_q == LAST_IDX) blk_valid_q <= 1'b1;
            end
            if (blk_fire) begin
                blk_valid_q <= 1'b0;
                if (in_cnt_q != nb_q) in_cnt_q <= in_cnt_q + CNT_W'(1);
            end

            // Unpack: ctb_ready requires an empty buffer, so load and drain never overlap.
            if (ctb_fire) begin
                ub_data_q <= ctb.data;
                ub_full_q <= 1'b1;
                ub_idx_q  <= '0;
            end else if (ct_fire) begin
                ub_data_q <= ub_data_q << WORD_W;
                ub_idx_q  <= (ub_idx_q == LAST_IDX) ? '0 : ub_idx_q + IDX_W'(1);
                if (ub_idx_q == LAST_IDX) begin
                    ub_full_q <= 1'b0;
                    if (out_cnt_q != nb_q) out_cnt_q <= out_cnt_q + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_aes_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_aes_stream_packer
// Self-checking bench for aes_stream_packer. The bench plays source streamer,
// AES core (block XOR key) and sink. A reference model built from queues of
// words and blocks predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_aes_stream_packer;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int CNT_W   = 16;
    localparam int WPB     = BLOCK_W / WORD_W;

    typedef logic [BLOCK_W-1:0] vec_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clear;
    logic             start_i;
    logic             enable_i;
    logic [CNT_W-1:0] nb_blocks_i;
    logic             busy_o;
    logic             done_o;
    logic [CNT_W-1:0] in_cnt_o;
    logic [CNT_W-1:0] out_cnt_o;

    aes_stream_packer_if #(.W(WORD_W))  pt ();
    aes_stream_packer_if #(.W(BLOCK_W)) blk ();
    aes_stream_packer_if #(.W(BLOCK_W)) ctb ();
    aes_stream_packer_if #(.W(WORD_W))  ct ();

    always #5 clk = ~clk;

    aes_stream_packer #(
        .WORD_W (WORD_W),
        .BLOCK_W(BLOCK_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (clear),
        .start_i    (start_i),
        .enable_i   (enable_i),
        .nb_blocks_i(nb_blocks_i),
        .pt         (pt),
        .blk        (blk),
        .ctb        (ctb),
        .ct         (ct),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .in_cnt_o   (in_cnt_o),
        .out_cnt_o  (out_cnt_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [WORD_W-1:0] pt_words[$];
    vec_t              exp_blk[$];
    vec_t              core_q[$];
    logic [WORD_W-1:0] exp_ct[$];
    vec_t              key;
    int pt_acc, blk_acc, ct_acc, nb_m, after, freeze_left, blk_wait;
    bit run_m, done_now, pt_pend, ctb_pend, en_m;

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pt_ready"},  vec_t'(pt.ready),  '0);
        check({tag, "_blk_valid"}, vec_t'(blk.valid), '0);
        check({tag, "_blk_data"},  blk.data,          '0);
        check({tag, "_ctb_ready"}, vec_t'(ctb.ready), '0);
        check({tag, "_ct_valid"},  vec_t'(ct.valid),  '0);
        check({tag, "_ct_data"},   vec_t'(ct.data),   '0);
        check({tag, "_busy"},      vec_t'(busy_o),    '0);
        check({tag, "_done"},      vec_t'(done_o),    '0);
        check({tag, "_in_cnt"},    vec_t'(in_cnt_o),  '0);
        check({tag, "_out_cnt"},   vec_t'(out_cnt_o), '0);
    endtask

    task automatic fill_random(input int nwords);
        pt_words.delete();
        for (int i = 0; i < nwords; i++) pt_words.push_back($urandom);
    endtask

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic start_job(input int nb);
        start_i     = 1'b1;
        nb_blocks_i = CNT_W'(nb);
        exp_blk.delete(); core_q.delete(); exp_ct.delete();
        pt_acc = 0; blk_acc = 0; ct_acc = 0; nb_m = nb;
        @(posedge clk); #1;
        start_i     = 1'b0;
        nb_blocks_i = CNT_W'($urandom);
        run_m    = (nb != 0);
        done_now = (nb == 0);
        after    = (nb == 0) ? 0 : -1;
    endtask

    task automatic run_job(input int pt_pct, input int blk_pct, input int blk_stall,
                           input int ctb_pct, input int ct_pct, input int freeze_at,
                           input int stop_at_pt, input bit noisy_start);
        int   cyc;
        bit   pf, bf, cf, tf;
        vec_t b;
        cyc = 0;
        pt_pend = 0; ctb_pend = 0; blk_wait = 0; freeze_left = 0;
        pt.valid = 1'b0; ctb.valid = 1'b0;
        while (after < 2 && cyc < 3000) begin
            en_m = (freeze_left == 0);
            if (freeze_left > 0) freeze_left--;
            enable_i = en_m;
            if (noisy_start && after < 0) begin
                start_i     = ($urandom_range(3) == 0);
                nb_blocks_i = CNT_W'($urandom);
            end else begin
                start_i = 1'b0;
            end
            if (!pt_pend) begin
                if (pt_acc < pt_words.size() && $urandom_range(99) < pt_pct) begin
                    pt.valid = 1'b1; pt.data = pt_words[pt_acc]; pt_pend = 1;
                end else begin
                    pt.valid = 1'b0; pt.data = $urandom;
                end
            end
            if (blk.valid && blk_wait < blk_stall) begin
                blk.ready = 1'b0; blk_wait++;
            end else begin
                blk.ready = ($urandom_range(99) < blk_pct);
            end
            if (!ctb_pend) begin
                if (core_q.size() != 0 && $urandom_range(99) < ctb_pct) begin
                    ctb.valid = 1'b1; ctb.data = core_q[0]; ctb_pend = 1;
                end else begin
                    ctb.valid = 1'b0; ctb.data = {$urandom, $urandom, $urandom, $urandom};
                end
            end
            ct.ready = ($urandom_range(99) < ct_pct);

            @(negedge clk);
            check("blk_valid", vec_t'(blk.valid), vec_t'(exp_blk.size() != 0));
            if (exp_blk.size() != 0) check("blk_data", blk.data, exp_blk[0]);
            check("ct_valid", vec_t'(ct.valid), vec_t'(exp_ct.size() != 0));
            if (exp_ct.size() != 0) check("ct_data", vec_t'(ct.data), vec_t'(exp_ct[0]));
            check("pt_ready", vec_t'(pt.ready),
                  vec_t'(run_m && en_m && exp_blk.size() == 0 && blk_acc < nb_m));
            check("ctb_ready", vec_t'(ctb.ready), vec_t'(run_m && en_m && exp_ct.size() == 0));
            check("in_cnt",  vec_t'(in_cnt_o),  vec_t'(blk_acc));
            check("out_cnt", vec_t'(out_cnt_o), vec_t'(ct_acc / WPB));
            check("done",    vec_t'(done_o),    vec_t'(done_now));
            check("busy",    vec_t'(busy_o),    vec_t'(run_m || done_now));
            pf = pt.valid && pt.ready;
            bf = blk.valid && blk.ready;
            cf = ctb.valid && ctb.ready;
            tf = ct.valid && ct.ready;

            @(posedge clk); #1;
            done_now = 0;
            if (after >= 0) after++;
            if (pf) begin
                pt_acc++;
                pt_pend = 0;
                if (pt_acc % WPB == 0)
                    exp_blk.push_back({pt_words[pt_acc-4], pt_words[pt_acc-3],
                                       pt_words[pt_acc-2], pt_words[pt_acc-1]});
                if (pt_acc == freeze_at) freeze_left = 10;
            end
            if (bf) begin
                if (exp_blk.size() != 0) begin
                    b = exp_blk.pop_front();
                    core_q.push_back(b ^ key);
                end
                blk_acc++;
                blk_wait = 0;
            end
            if (tf) begin
                if (exp_ct.size() != 0) void'(exp_ct.pop_front());
                ct_acc++;
                if (ct_acc == nb_m * WPB) begin
                    run_m = 0; done_now = 1; after = 0;
                end
            end
            if (cf) begin
                if (core_q.size() != 0) begin
                    b = core_q.pop_front();
                    for (int k = 0; k < WPB; k++)
                        exp_ct.push_back(b[BLOCK_W-1-k*WORD_W -: WORD_W]);
                end
                ctb_pend = 0;
            end
            cyc++;
            if (stop_at_pt > 0 && pt_acc >= stop_at_pt) break;
        end
        if (stop_at_pt == 0 && after < 2)
            check("job_timeout", vec_t'(ct_acc), vec_t'(nb_m * WPB));
        pt.valid  = 1'b0;
        ctb.valid = 1'b0;
        enable_i  = 1'b1;
    endtask

    initial begin
        // Reset with random inputs: every output must stay 0
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clear = $urandom; start_i = $urandom; enable_i = $urandom;
            nb_blocks_i = CNT_W'($urandom);
            pt.valid = $urandom; pt.data = $urandom;
            blk.ready = $urandom; ct.ready = $urandom;
            ctb.valid = $urandom; ctb.data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check_all_zero("reset");
            @(posedge clk); #1;
        end
        clear = 1'b0; start_i = 1'b0; enable_i = 1'b1;
        pt.valid = 1'b0; ctb.valid = 1'b0; blk.ready = 1'b0; ct.ready = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_busy",     vec_t'(busy_o),   '0);
        check("post_reset_pt_ready", vec_t'(pt.ready), '0);
        @(posedge clk); #1;

        // Single block, loopback core, full throughput
        pt_words.delete();
        pt_words.push_back(32'h00112233); pt_words.push_back(32'h44556677);
        pt_words.push_back(32'h8899AABB); pt_words.push_back(32'hCCDDEEFF);
        key = '0;
        start_job(1);
        run_job(100, 100, 0, 100, 100, -1, 0, 0);

        // Backpressure: 3 blocks, 5-cycle core stalls, 50% sink, extra pt words offered
        key = {$urandom, $urandom, $urandom, $urandom};
        fill_random(3 * WPB + 3);
        start_job(3);
        run_job(70, 100, 5, 80, 50, -1, 0, 1);

        // Zero blocks
        start_job(0);
        run_job(100, 100, 0, 100, 100, -1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_pt_ready",  vec_t'(pt.ready),  '0);
            check("idle_ctb_ready", vec_t'(ctb.ready), '0);
            @(posedge clk); #1;
        end

        // Enable freeze after the 2nd pt word
        key = {$urandom, $urandom, $urandom, $urandom};
        fill_random(2 * WPB);
        start_job(2);
        run_job(100, 100, 0, 100, 100, 2, 0, 0);

        // Clear mid-job after 6 pt words (start in the same cycle must lose to clear)
        fill_random(4 * WPB);
        start_job(4);
        run_job(100, 60, 0, 100, 60, -1, 6, 0);
        clear = 1'b1; start_i = 1'b1; nb_blocks_i = CNT_W'(2);
        @(posedge clk); #1;
        clear = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check_all_zero("clear");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("clear_no_done", vec_t'(done_o), '0);
            check("clear_idle",    vec_t'(busy_o), '0);
        end
        @(posedge clk); #1;

        // Fresh job after clear
        fill_random(WPB);
        start_job(1);
        run_job(60, 70, 0, 70, 70, -1, 0, 0);

        // Longer random job
        key = {$urandom, $urandom, $urandom, $urandom};
        fill_random(6 * WPB);
        start_job(6);
        run_job(60, 60, 2, 60, 60, 9, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
